// File: rtl/reg_scan_pkg.sv
// Shared definitions for the debug register-file scanner: FSM states,
// default register-file geometry (matches sccomp) and the select-width helper.
package reg_scan_pkg;

  localparam int unsigned NREG_DEFAULT = 32;
  localparam int unsigned DW_DEFAULT   = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_PRESENT
  } state_e;

  function automatic int unsigned sel_width(input int unsigned nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/reg_scan.sv
// Walks the CPU debug port reg_sel over all registers and streams (index, value)
// beats on a valid/ready interface. Define REG_SCAN_SKIP_ZERO_EN to skip register 0.
module reg_scan
  import reg_scan_pkg::*;
#(
  parameter int unsigned NREG   = NREG_DEFAULT,
  parameter int unsigned DW     = DW_DEFAULT,
  parameter int unsigned SETTLE = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         abort,
  output logic [sel_width(NREG)-1:0]   reg_sel,
  input  logic [DW-1:0]                reg_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [sel_width(NREG)-1:0]   out_idx,
  output logic [DW-1:0]                out_data,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned SEL_W = sel_width(NREG);
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] LAST     = SEL_W'(NREG - 1);
`ifdef REG_SCAN_SKIP_ZERO_EN
  localparam logic [SEL_W-1:0] FIRST    = SEL_W'(1);
`else
  localparam logic [SEL_W-1:0] FIRST    = '0;
`endif

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  oidx_q, oidx_d;
  logic [DW-1:0]     odata_q, odata_d;
  logic              done_q, done_d;

  // NOTE: every next-state signal takes its hold value first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    oidx_d  = oidx_q;
    odata_d = odata_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          idx_d   = FIRST;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          odata_d = reg_data;
          oidx_d  = idx_q;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + SEL_W'(1);
            cnt_d   = CNT_LOAD;
            state_d = ST_SETTLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Cancel wins over a same-cycle handshake and never produces done.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
      idx_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      oidx_q  <= '0;
      odata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      oidx_q  <= oidx_d;
      odata_q <= odata_d;
      done_q  <= done_d;
    end
  end

  assign reg_sel   = idx_q;
  assign out_valid = valid_q;
  assign out_idx   = oidx_q;
  assign out_data  = odata_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_reg_scan.sv
// Directed bench for reg_scan: full scan timing, backpressure, dropped restart,
// abort against handshake, mid-scan reset and start+abort in IDLE.
module tb_reg_scan;

  localparam int NREG   = 32;
  localparam int DW     = 32;
  localparam int SETTLE = 1;
  localparam int SEL_W  = $clog2(NREG);
`ifdef REG_SCAN_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic             clk       = 1'b0;
  logic             rstn      = 1'b0;
  logic             start     = 1'b0;
  logic             abort     = 1'b0;
  logic             out_ready = 1'b0;
  logic [SEL_W-1:0] reg_sel;
  logic [SEL_W-1:0] out_idx;
  logic [DW-1:0]    reg_data;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // CPU register file model: register i holds 0x100 + i.
  assign reg_data = DW'(32'h100 + 32'(reg_sel));

  reg_scan #(.NREG(NREG), .DW(DW), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .reg_sel   (reg_sel),
    .reg_data  (reg_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " reg_sel"},   reg_sel,   0);
    check({nm, " out_valid"}, out_valid, 0);
    check({nm, " out_idx"},   out_idx,   0);
    check({nm, " out_data"},  out_data,  0);
    check({nm, " busy"},      busy,      0);
    check({nm, " done"},      done,      0);
  endtask

  // One scan from a start pulse (cycle 0). Negative arguments disable an event.
  task automatic run_scan(input string nm, input int stall_at, input int restart_at,
                          input int abort_at, input int rst_at);
    int cyc       = 1;
    int beats     = 0;
    int dones     = 0;
    int done_cyc  = -1;
    int exp_idx   = FIRST;
    int stall     = 0;
    int exp_cyc;
    bit counted   = 1'b0;
    bit restarted = 1'b0;

    start = 1'b1; abort = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check({nm, " busy_c1"},  busy,      1);
    check({nm, " sel_c1"},   reg_sel,   FIRST);
    check({nm, " valid_c1"}, out_valid, 0);

    while (cyc < 300 && (done_cyc < 0 || cyc <= done_cyc + 3)) begin
      start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      if (done) begin
        dones++;
        done_cyc = cyc;
      end

      if (rst_at >= 0 && busy && !out_valid && int'(reg_sel) == rst_at) begin
        rstn = 1'b0;
        #1;
        check_reset_outputs({nm, " async_rst"});
        rstn = 1'b1;
        tick();
        check({nm, " idle_after_rst"}, busy, 0);
        return;
      end

      if (out_valid && !counted) begin
        counted = 1'b1;
        beats++;
        exp_cyc = 2 + 2 * (exp_idx - FIRST) + ((stall_at >= 0 && exp_idx > stall_at) ? 5 : 0);
        check({nm, " beat_idx"},   out_idx,  exp_idx);
        check({nm, " beat_data"},  out_data, 32'h100 + exp_idx);
        check({nm, " beat_cycle"}, cyc,      exp_cyc);
      end

      if (abort_at >= 0 && out_valid && int'(out_idx) == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check({nm, " valid_after_abort"}, out_valid, 0);
        check({nm, " busy_after_abort"},  busy,      0);
        check({nm, " done_after_abort"},  done,      0);
        check({nm, " sel_after_abort"},   reg_sel,   0);
        tick();
        check({nm, " no_late_done"}, done, 0);
        return;
      end

      if (stall_at >= 0 && out_valid && int'(out_idx) == stall_at && stall < 5) begin
        out_ready = 1'b0;
        stall++;
        check({nm, " stall_idx"},  out_idx,  stall_at);
        check({nm, " stall_data"}, out_data, 32'h100 + stall_at);
        check({nm, " stall_sel"},  reg_sel,  stall_at);
      end

      if (restart_at >= 0 && out_valid && int'(out_idx) == restart_at && !restarted) begin
        start     = 1'b1;
        restarted = 1'b1;
      end

      if (out_valid && out_ready) begin
        counted = 1'b0;
        exp_idx++;
      end
      tick();
      cyc++;
    end

    check({nm, " beats"},     beats,    NREG - FIRST);
    check({nm, " done_count"}, dones,   1);
    check({nm, " done_cycle"}, done_cyc, 65 - 2 * FIRST + ((stall_at >= 0) ? 5 : 0));
    check({nm, " busy_end"},  busy,      0);
    check({nm, " valid_end"}, out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();
    check_reset_outputs("idle");

    run_scan("full", -1, -1, -1, -1);
    repeat (2) tick();
    run_scan("stall_restart", 7, 3, -1, -1);
    run_scan("abort", -1, -1, 10, -1);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort busy", busy,    1);
    check("start_abort sel",  reg_sel, FIRST);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_settle busy", busy, 0);
    check("abort_settle done", done, 0);

    run_scan("midscan_rst", -1, -1, -1, 20);
    run_scan("after_rst", -1, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
